column_window_buffer: RTL and testbench

COLUMN_WINDOW_BUFFER -- requirements
Module: column_window_buffer

---
 rtl/column_window_buffer_pkg.sv | 13 +
 rtl/column_window_buffer_line_bank.sv | 22 ++
 rtl/my_header.vh | 8 +
 rtl/column_window_buffer.sv | 121 ++++++++++++
 tb/tb_column_window_buffer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/column_window_buffer_pkg.sv
// rtl/column_window_buffer_pkg.sv - shared sizing defaults and bank-rotation helper
`include "my_header.vh"
package column_window_buffer_pkg;
    localparam int DEF_DW   = `DWIDTH_DAT;
    localparam int DEF_ROWS = `DWIDTH_SLICE;
    localparam int DEF_COLS = `HWIDTH;
    localparam int DEF_BW   = `AWIDTH_PBUFF;

    // circular bank index: (base + off) mod nb
    function automatic int bank_add(input int base, input int off, input int nb);
        return (base + off) % nb;
    endfunction
endpackage

// File: rtl/column_window_buffer_line_bank.sv
// rtl/column_window_buffer_line_bank.sv - one line of pixels, single-write single-read sync RAM
module line_bank #(
    parameter int DW   = 12,
    parameter int COLS = 640,
    parameter int AW   = $clog2(COLS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [COLS];

    // contents are never cleared; the top masks stale lines by committed count
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/my_header.vh
// rtl/my_header.vh - default pixel, row, line and bank-index sizes
`ifndef MY_HEADER_VH
`define MY_HEADER_VH
`define DWIDTH_DAT   12
`define DWIDTH_SLICE 3
`define HWIDTH       640
`define AWIDTH_PBUFF 2
`endif

// File: rtl/column_window_buffer.sv
// rtl/column_window_buffer.sv - ROWS-tall column window over ROWS+1 rotating line banks; COLBUF_EDGE_PAD_EN replicates the oldest row into empty slots
module column_window_buffer
    import column_window_buffer_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int AW   = $clog2(COLS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sof,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      din,
    input  logic               rd_en,
    input  logic [AW-1:0]      raddr,
    output logic [DW*ROWS-1:0] col_out,
    output logic               col_valid,
    output logic               line_done,
    output logic               win_full
);
    localparam int NB     = ROWS + 1;
    localparam int BW_MIN = $clog2(NB);
    localparam int BW     = (BW_MIN > DEF_BW) ? BW_MIN : DEF_BW;
    localparam int CW     = $clog2(ROWS + 1);

    logic [AW-1:0] r_wcol;
    logic [CW-1:0] r_count;
    logic [BW-1:0] r_wbank;
    logic          r_in_ready;
    logic          r_line_done;
    logic          r_col_valid;
    logic          r_have;
    logic [BW-1:0] r_rd_base;
    logic [CW-1:0] r_rd_cnt;
    logic          r_rd_oor;

    logic          w_accept;
    logic [AW-1:0] w_wcol_eff;
    logic          w_last;
    logic          w_in_range;
    logic [BW-1:0] w_base;
    logic [DW-1:0] w_q [NB];
    logic [DW*ROWS-1:0] w_col;

    assign w_accept   = in_valid && r_in_ready;
    assign w_wcol_eff = sof ? '0 : r_wcol;
    assign w_last     = w_accept && (w_wcol_eff == AW'(COLS - 1));
    assign w_in_range = (32'(raddr) < COLS);
    // slot 0 is the oldest committed line, count banks behind the write bank
    assign w_base     = BW'(bank_add(int'(r_wbank), NB - int'(r_count), NB));

    for (genvar b = 0; b < NB; b++) begin : g_bank
        line_bank #(.DW(DW), .COLS(COLS), .AW(AW)) u_bank (
            .i_clk   (clk),
            .i_we    (w_accept && (r_wbank == BW'(b))),
            .i_waddr (w_wcol_eff),
            .i_wdata (din),
            .i_re    (rd_en && w_in_range),
            .i_raddr (raddr),
            .o_rdata (w_q[b])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcol      <= '0;
            r_count     <= '0;
            r_wbank     <= '0;
            r_in_ready  <= 1'b0;
            r_line_done <= 1'b0;
            r_col_valid <= 1'b0;
            r_have      <= 1'b0;
            r_rd_base   <= '0;
            r_rd_cnt    <= '0;
            r_rd_oor    <= 1'b0;
        end else begin
            r_in_ready  <= 1'b1;
            r_line_done <= w_last;
            r_col_valid <= rd_en && (r_count != '0);
            if (w_accept)
                r_wcol <= w_last ? '0 : w_wcol_eff + 1'b1;
            else if (sof)
                r_wcol <= '0;
            if (sof)
                r_count <= '0;
            else if (w_last && (r_count != CW'(ROWS)))
                r_count <= r_count + 1'b1;
            if (w_last)
                r_wbank <= (r_wbank == BW'(NB - 1)) ? '0 : r_wbank + 1'b1;
            // arrangement is frozen at request time so a same-cycle commit is invisible
            if (rd_en) begin
                r_have    <= 1'b1;
                r_rd_base <= w_base;
                r_rd_cnt  <= r_count;
                r_rd_oor  <= !w_in_range;
            end
        end
    end

    always_comb begin
        w_col = '0;
        if (r_have && !r_rd_oor) begin
            for (int k = 0; k < ROWS; k++) begin
                if (k < int'(r_rd_cnt))
                    w_col[k*DW +: DW] = w_q[BW'(bank_add(int'(r_rd_base), k, NB))];
`ifdef COLBUF_EDGE_PAD_EN
                else if (r_rd_cnt != '0)
                    w_col[k*DW +: DW] = w_q[r_rd_base];
`endif
            end
        end
    end

    assign col_out   = w_col;
    assign col_valid = r_col_valid;
    assign line_done = r_line_done;
    assign win_full  = (r_count == CW'(ROWS));
    assign in_ready  = r_in_ready;
endmodule

// File: tb/tb_column_window_buffer.sv
// tb/tb_column_window_buffer.sv - directed checks of column_window_buffer at DW=12 ROWS=3 COLS=8
module tb_column_window_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        sof;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] din;
    logic        rd_en;
    logic [3:0]  raddr;
    logic [35:0] col_out;
    logic        col_valid;
    logic        line_done;
    logic        win_full;

    int checks = 0;
    int errors = 0;
    int ld_cnt = 0;

    column_window_buffer #(.DW(12), .ROWS(3), .COLS(8), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sof       (sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .rd_en     (rd_en),
        .raddr     (raddr),
        .col_out   (col_out),
        .col_valid (col_valid),
        .line_done (line_done),
        .win_full  (win_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (line_done) ld_cnt++;
    endtask

    function automatic logic [35:0] col3(input logic [11:0] newest, input logic [11:0] mid,
                                         input logic [11:0] oldest);
        return {newest, mid, oldest};
    endfunction

    task automatic put_line(input logic [11:0] base, input int first, input int last);
        for (int c = first; c <= last; c++) begin
            in_valid = 1'b1;
            din      = base + 12'(c);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_en = 1'b1;
        raddr = a;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sof = 1'b0; in_valid = 1'b0; din = '0; rd_en = 1'b0; raddr = '0;
        repeat (3) tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_col_valid", 64'(col_valid), 64'd0);
        check("rst_line_done", 64'(line_done), 64'd0);
        check("rst_win_full", 64'(win_full), 64'd0);
        check("rst_col_out", 64'(col_out), 64'd0);
        rst = 1'b1;
        #2;
        check("release_in_ready_lo", 64'(in_ready), 64'd0);
        tick();
        check("release_in_ready_hi", 64'(in_ready), 64'd1);

        rd(4'd1);
        check("empty_read_valid", 64'(col_valid), 64'd0);
        check("empty_read_col", 64'(col_out), 64'd0);

        put_line(12'h100, 0, 7);
        check("l1_line_done", 64'(line_done), 64'd1);
        check("l1_win_full", 64'(win_full), 64'd0);
        rd(4'd2);
        check("l1_valid", 64'(col_valid), 64'd1);
`ifdef COLBUF_EDGE_PAD_EN
        check("l1_col_pad", 64'(col_out), 64'(col3(12'h102, 12'h102, 12'h102)));
`else
        check("l1_col_zero", 64'(col_out), 64'(col3(12'h000, 12'h000, 12'h102)));
`endif
        check("l1_pulse_once", 64'(line_done), 64'd0);

        put_line(12'h200, 0, 7);
        put_line(12'h300, 0, 7);
        check("l3_win_full", 64'(win_full), 64'd1);
        check("l3_done_pulses", 64'(ld_cnt), 64'd3);
        rd(4'd5);
        check("l3_col", 64'(col_out), 64'(col3(12'h305, 12'h205, 12'h105)));
        check("l3_valid", 64'(col_valid), 64'd1);
        repeat (2) tick();
        check("hold_col", 64'(col_out), 64'(col3(12'h305, 12'h205, 12'h105)));
        check("hold_valid_lo", 64'(col_valid), 64'd0);

        put_line(12'h400, 0, 6);
        in_valid = 1'b1; din = 12'h407; rd_en = 1'b1; raddr = 4'd7;
        tick();
        in_valid = 1'b0; rd_en = 1'b0;
        check("commit_read_col", 64'(col_out), 64'(col3(12'h307, 12'h207, 12'h107)));
        check("commit_line_done", 64'(line_done), 64'd1);
        rd(4'd7);
        check("post_commit_col", 64'(col_out), 64'(col3(12'h407, 12'h307, 12'h207)));
        check("l4_win_full", 64'(win_full), 64'd1);

        rd(4'd9);
        check("oor_col", 64'(col_out), 64'd0);
        check("oor_valid", 64'(col_valid), 64'd1);

        put_line(12'h500, 0, 3);
        sof = 1'b1; in_valid = 1'b1; din = 12'hABC;
        tick();
        sof = 1'b0; in_valid = 1'b0;
        check("sof_win_full", 64'(win_full), 64'd0);
        rd(4'd0);
        check("sof_count_zero", 64'(col_valid), 64'd0);
        put_line(12'hAB0, 1, 6);
        check("sof_no_early_done", 64'(line_done), 64'd0);
        put_line(12'hAB0, 7, 7);
        check("sof_line_done", 64'(line_done), 64'd1);
        rd(4'd0);
`ifdef COLBUF_EDGE_PAD_EN
        check("sof_col", 64'(col_out), 64'(col3(12'hABC, 12'hABC, 12'hABC)));
`else
        check("sof_col", 64'(col_out), 64'(col3(12'h000, 12'h000, 12'hABC)));
`endif

        put_line(12'h700, 0, 2);
        rst = 1'b0;
        #1;
        check("mid_rst_col_out", 64'(col_out), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_win_full", 64'(win_full), 64'd0);
        check("mid_rst_line_done", 64'(line_done), 64'd0);
        tick();
        rst = 1'b1;
        #2;
        check("mid_rel_in_ready_lo", 64'(in_ready), 64'd0);
        tick();
        check("mid_rel_in_ready_hi", 64'(in_ready), 64'd1);
        rd(4'd0);
        check("mid_rel_read_valid", 64'(col_valid), 64'd0);
        check("mid_rel_read_col", 64'(col_out), 64'd0);
        put_line(12'h600, 0, 6);
        check("wcol_cleared_no_done", 64'(line_done), 64'd0);
        put_line(12'h600, 7, 7);
        check("wcol_cleared_done", 64'(line_done), 64'd1);
        rd(4'd3);
`ifdef COLBUF_EDGE_PAD_EN
        check("after_rst_col", 64'(col_out), 64'(col3(12'h603, 12'h603, 12'h603)));
`else
        check("after_rst_col", 64'(col_out), 64'(col3(12'h000, 12'h000, 12'h603)));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
